fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single write port of the dual-clock sim_fifo among
//   NUM_REQ producers in the wr_clk domain. Grants one requester at a time for a burst of
//   up to MAX_BURST words, gates writes on fifo_full so no word is lost, and keeps a
//   saturating stall counter for the emulation shell status registers.
// PARAMETERS
//   NUM_REQ    4    number of requesters (2..8)
//   DATA_W     16   word width, equal to the FIFO din width
//   MAX_BURST  8    max words per grant before forced re-arbitration (1..255)
// PORTS
//   wr_clk       in   1               write-domain clock, all logic on rising edge
//   reset        in   1               reset, asynchronous, active-high
//   enable       in   1               1 = new grants allowed; 0 = finish current burst, then idle
//   req_valid    in   NUM_REQ         per-requester word valid
//   req_data     in   NUM_REQ*DATA_W  per-requester word; requester i at [i*DATA_W +: DATA_W]
//   req_ready    out  NUM_REQ         per-requester accept; word i transfers when valid&ready
//   fifo_full    in   1               FIFO full flag (wr_clk domain)
//   fifo_din     out  DATA_W          FIFO write data
//   fifo_wr_en   out  1               FIFO write enable
//   grant_id     out  3               index of granted requester (valid while busy=1)
//   busy         out  1               1 while in GRANT state
//   stall_count  out  16              saturating count of cycles blocked by fifo_full
// BEHAVIOUR
//   Reset (async): state=IDLE, rr_ptr=NUM_REQ-1, burst_cnt=0, grant_id=0, stall_count=0;
//     hence busy=0, fifo_wr_en=0, req_ready=0, fifo_din=0.
//   States: IDLE, GRANT (registered).
//   IDLE: if enable && |req_valid: grant = first i with req_valid[i], searching rr_ptr+1,
//     rr_ptr+2, ... modulo NUM_REQ; next edge -> GRANT, grant_id=i, rr_ptr=i, burst_cnt=0.
//     Otherwise remain IDLE. One idle cycle (bubble) always separates two grants.
//   GRANT (combinational outputs, no added latency):
//     fifo_wr_en = req_valid[grant_id] & ~fifo_full
//     req_ready[grant_id] = fifo_wr_en; all other req_ready = 0
//     fifo_din = req_data[grant_id]; in IDLE fifo_din = 0.
//   Each transfer increments burst_cnt. Leave GRANT -> IDLE at the edge where either:
//     (a) a transfer occurs with burst_cnt == MAX_BURST-1 (burst exhausted), or
//     (b) req_valid[grant_id] == 0 (requester released; no transfer that cycle).
//   fifo_full with valid high: hold GRANT, no transfer, burst_cnt unchanged, stall_count += 1
//     (saturates at 16'hFFFF, never wraps). stall_count counts nowhere else.
//   enable deassert mid-burst: current burst continues to completion per (a)/(b); no new grant
//     until enable=1.
//   Requesters must hold req_valid/req_data stable until accepted; dropping valid ends grant.
//   NUM_REQ=1: rr search trivially returns 0; behaviour otherwise identical.
//   Reset mid-burst: immediate return to reset values; in-flight word not written.
//   fifo_wr_en never asserted while fifo_full=1 (overflow impossible by construction).
// TESTING
//   1 Reset: assert reset 2 cycles with all req_valid=1 -> fifo_wr_en=0, busy=0, stall_count=0.
//   2 Single requester: req 2 streams 0x0001.. continuously, full=0 -> 8 writes 0x0001..0x0008,
//     1 idle cycle, next 8 writes 0x0009..0x0010; grant_id=2 throughout.
//   3 Round-robin: all 4 valid constantly -> grant order 0,1,2,3,0; each burst exactly 8 words.
//   4 Backpressure: during grant of req 1 hold fifo_full=1 for 5 cycles after 3 words ->
//     no wr_en during stall, stall_count=5, burst resumes and ends after 5 more words.
//   5 Early release: req 3 valid for 3 words then drops -> 3 writes, GRANT->IDLE, next
//     valid requester after index 3 (wraps to 0) granted.
//   6 Enable/saturation: enable=0 mid-burst -> burst completes, no regrant; hold full=1 with
//     valid for 70000 cycles -> stall_count sticks at 0xFFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the requester handshake lanes and the shared FIFO write port.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic [DATA_W-1:0]         fifo_din;
  logic                      fifo_wr_en;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_din, fifo_wr_en
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_din, fifo_wr_en
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with bounded
// bursts, fifo_full gating and a saturating stall counter.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic               wr_clk,
  input  logic               reset,
  input  logic               enable,
  fifo_wr_arbiter_if.master  bus,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic [15:0]        stall_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [2:0] RR_INIT   = 3'(NUM_REQ - 1);
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_e              state_q, state_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [2:0]          grant_id_q, grant_id_d;
  logic [7:0]          burst_cnt_q, burst_cnt_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;

  logic                found_s;
  logic [2:0]          pick_s;
  logic                sel_valid_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                wr_en_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic [DATA_W-1:0]   din_s;

  // State registers
  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= RR_INIT;
      grant_id_q  <= 3'd0;
      burst_cnt_q <= 8'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Round-robin search starting after rr_ptr, and mux of the granted requester's lane
  always_comb begin
    found_s     = 1'b0;
    pick_s      = 3'd0;
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found_s && bus.req_valid[i] && (((int'(rr_ptr_q) + k) % NUM_REQ) == i)) begin
          found_s = 1'b1;
          pick_s  = 3'(i);
        end else begin
          found_s = found_s;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        sel_valid_s = bus.req_valid[i];
        sel_data_s  = bus.req_data[i*DATA_W +: DATA_W];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Next state, burst/stall bookkeeping and FIFO write-port outputs
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    wr_en_s     = 1'b0;
    ready_s     = '0;
    din_s       = '0;
    case (state_q)
      ST_IDLE: begin
        if (enable && found_s) begin
          state_d     = ST_GRANT;
          grant_id_d  = pick_s;
          rr_ptr_d    = pick_s;
          burst_cnt_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        wr_en_s = sel_valid_s & ~bus.fifo_full;
        din_s   = sel_data_s;
        for (int i = 0; i < NUM_REQ; i++) begin
          ready_s[i] = wr_en_s & (grant_id_q == 3'(i));
        end
        // A dropped valid releases the grant; a full FIFO holds it without losing the word.
        if (!sel_valid_s) begin
          state_d = ST_IDLE;
        end else if (bus.fifo_full) begin
          if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end else begin
            stall_cnt_d = stall_cnt_q;
          end
        end else begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (burst_cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GRANT;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready  = ready_s;
  assign bus.fifo_din   = din_s;
  assign bus.fifo_wr_en = wr_en_s;
  assign grant_id       = grant_id_q;
  assign busy           = (state_q == ST_GRANT);
  assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed requester streams push expected writes,
// a negedge monitor pops and compares every FIFO write (grant, data, spacing).
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [2:0]  gid;
    logic [15:0] data;
    logic [7:0]  gap;   // cycles since previous write; 0 = not checked
  } exp_t;

  logic        wr_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  grant_id;
  logic        busy;
  logic [15:0] stall_count;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(8)) dut (
    .wr_clk      (wr_clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .stall_count (stall_count)
  );

  exp_t          exp_q[$];
  logic [15:0]   src_q[NR][$];
  int            tests   = 0;
  int            fails   = 0;
  int            cyc     = 0;
  int            last_wr = 0;
  logic          hold_all = 1'b0;
  logic [NR-1:0] drv_acc;
  logic [NR-1:0] drv_v;
  logic [NR*DW-1:0] drv_d;

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge wr_clk);
      #2;
    end
  endtask

  task automatic load(input int i, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) src_q[i].push_back(base + 16'(k));
  endtask

  task automatic push_burst(input logic [2:0] g, input logic [15:0] base, input int n,
                            input logic [7:0] first_gap);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.gid  = g;
      e.data = base + 16'(k);
      e.gap  = (k == 0) ? first_gap : 8'd1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_src(input int i, input int n);
    int c;
    c = 0;
    while (src_q[i].size() != n && c < 300) begin
      step(1);
      c++;
    end
    check("wait_src_level", 32'(src_q[i].size()), 32'(n));
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && c < 500) begin
      step(1);
      c++;
    end
    check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Requester models: retire accepted words, then present each queue head
  initial forever begin
    @(negedge wr_clk);
    drv_acc = bus.req_valid & bus.req_ready;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (drv_acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (hold_all) begin
        drv_v[i] = 1'b1;
        drv_d[i*DW +: DW] = 16'h0000;
      end else if (src_q[i].size() > 0) begin
        drv_v[i] = 1'b1;
        drv_d[i*DW +: DW] = src_q[i][0];
      end else begin
        drv_v[i] = 1'b0;
        drv_d[i*DW +: DW] = 16'h0000;
      end
    end
    bus.req_valid = drv_v;
    bus.req_data  = drv_d;
  end

  // Monitor: every FIFO write must match the next expected entry
  initial forever begin
    exp_t e;
    @(negedge wr_clk);
    cyc++;
    if (bus.fifo_full === 1'b1) check("no_wr_while_full", 32'(bus.fifo_wr_en), 32'd0);
    if (bus.fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got gid %0d din %h, want no write", grant_id, bus.fifo_din);
      end else begin
        e = exp_q.pop_front();
        check("write_gid_din", {13'd0, grant_id, bus.fifo_din}, {13'd0, e.gid, e.data});
        check("write_ready", 32'(bus.req_ready), 32'(4'b0001 << e.gid));
        if (e.gap != 8'd0) check("write_gap", 32'(cyc - last_wr), 32'(e.gap));
      end
      last_wr = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    enable         = 1'b1;
    hold_all       = 1'b1;
    bus.fifo_full  = 1'b0;
    bus.req_valid  = '1;
    bus.req_data   = '0;

    // Reset held with every requester valid
    step(2);
    check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall_count), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_din", 32'(bus.fifo_din), 32'd0);
    hold_all = 1'b0;
    step(1);
    reset = 1'b0;
    step(1);

    // Single requester: two 8-word bursts separated by one bubble
    load(2, 16'h0001, 16);
    push_burst(3'd2, 16'h0001, 8, 8'd0);
    push_burst(3'd2, 16'h0009, 8, 8'd2);
    wait_idle("single");

    // Round-robin from reset pointer: 0,1,2,3,0
    do_reset();
    load(0, 16'h0001, 16);
    load(1, 16'h0101, 8);
    load(2, 16'h0201, 8);
    load(3, 16'h0301, 8);
    push_burst(3'd0, 16'h0001, 8, 8'd0);
    push_burst(3'd1, 16'h0101, 8, 8'd2);
    push_burst(3'd2, 16'h0201, 8, 8'd2);
    push_burst(3'd3, 16'h0301, 8, 8'd2);
    push_burst(3'd0, 16'h0009, 8, 8'd2);
    wait_idle("round_robin");

    // Backpressure: 3 words, 5 full cycles, 5 more words
    load(1, 16'h1101, 8);
    push_burst(3'd1, 16'h1101, 3, 8'd0);
    push_burst(3'd1, 16'h1104, 5, 8'd6);
    wait_src(1, 5);
    bus.fifo_full = 1'b1;
    step(2);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_grant", 32'(grant_id), 32'd1);
    step(3);
    bus.fifo_full = 1'b0;
    wait_idle("backpressure");
    check("stall_count_5", 32'(stall_count), 32'd5);

    // Early release of req 3, then wrap to 0 and on to 1
    load(3, 16'h3301, 3);
    load(0, 16'h0A01, 2);
    load(1, 16'h1A01, 2);
    push_burst(3'd3, 16'h3301, 3, 8'd0);
    push_burst(3'd0, 16'h0A01, 2, 8'd3);
    push_burst(3'd1, 16'h1A01, 2, 8'd3);
    wait_idle("early_release");

    // Enable dropped mid-burst: burst completes, no new grant
    load(2, 16'h2201, 10);
    push_burst(3'd2, 16'h2201, 8, 8'd0);
    wait_src(2, 8);
    enable = 1'b0;
    wait_idle("enable_off");
    step(20);
    check("no_regrant_busy", 32'(busy), 32'd0);
    check("no_regrant_left", 32'(src_q[2].size()), 32'd2);

    // Long full with valid: stall counter saturates
    push_burst(3'd2, 16'h2209, 2, 8'd0);
    bus.fifo_full = 1'b1;
    enable = 1'b1;
    step(3);
    check("sat_busy", 32'(busy), 32'd1);
    check("sat_grant", 32'(grant_id), 32'd2);
    step(70000);
    check("stall_saturated", 32'(stall_count), 32'h0000FFFF);
    step(10);
    check("stall_sticks", 32'(stall_count), 32'h0000FFFF);
    bus.fifo_full = 1'b0;
    wait_idle("saturation");

    // Reset mid-burst: in-flight word dropped, outputs cleared at once
    load(1, 16'h1C01, 4);
    push_burst(3'd1, 16'h1C01, 1, 8'd0);
    wait_src(1, 3);
    reset = 1'b1;
    #1;
    check("midrst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_stall", 32'(stall_count), 32'd0);
    check("midrst_grant", 32'(grant_id), 32'd0);
    src_q[1].delete();
    step(2);
    reset = 1'b0;
    step(3);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
